// File: rtl/vector_result_serializer_pkg.sv
// Shared types for the vector result serializer: element type, default sizes
// and the two-state streaming FSM encoding.
package vec_pkg;

    localparam int VEC_SIZE = 5;
    localparam int DATA_W   = 32;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

endpackage

// File: rtl/vector_result_serializer_if.sv
// Capture/stream/sum bundle between a vector producer, the serializer and
// the downstream element consumer.
interface vector_result_serializer_if
    import vec_pkg::*;
#(
    parameter int VEC_SIZE = vec_pkg::VEC_SIZE,
    parameter int IDX_W    = $clog2(VEC_SIZE + 1)
);

    logic                    in_valid;
    logic                    in_ready;
    data_t [VEC_SIZE-1:0]    in_vec;
    logic                    out_valid;
    logic                    out_ready;
    data_t                   out_data;
    logic [IDX_W-1:0]        out_index;
    logic                    out_last;
    logic                    sum_valid;
    data_t                   sum_data;

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last,
               sum_valid, sum_data
    );

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last,
               sum_valid, sum_data
    );

endinterface

// File: rtl/vector_result_serializer.sv
// Captures a whole result vector in one beat, streams its elements in index
// order and pulses the wrapping sum once the last element is accepted.
module vector_result_serializer
    import vec_pkg::*;
#(
    parameter int VEC_SIZE = vec_pkg::VEC_SIZE,
    parameter int IDX_W    = $clog2(VEC_SIZE + 1)
) (
    input logic                        clk,
    input logic                        rst,
    vector_result_serializer_if.slave  bus
);

    ser_state_t        r_state;
    ser_state_t        w_next;
    data_t             r_buf [VEC_SIZE];
    logic [IDX_W-1:0]  r_idx;
    data_t             r_sum;
    data_t             r_sum_data;
    logic              r_sum_valid;

    logic              w_last;
    logic              w_cap;
    logic              w_fire;
    data_t             w_elem;

    assign w_last = (r_idx == IDX_W'(VEC_SIZE - 1));
    assign w_cap  = (r_state == IDLE) && bus.in_valid;
    assign w_fire = (r_state == SEND) && bus.out_ready;
    assign w_elem = r_buf[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cap) w_next = SEND;
            SEND:    if (w_fire && w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are gated to zero outside SEND so IDLE always shows reset values.
    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == SEND);
        bus.out_data  = '0;
        bus.out_index = '0;
        bus.out_last  = 1'b0;
        if (r_state == SEND) begin
            bus.out_data  = w_elem;
            bus.out_index = r_idx;
            bus.out_last  = w_last;
        end
        bus.sum_valid = r_sum_valid;
        bus.sum_data  = r_sum_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < VEC_SIZE; i++) begin
                r_buf[i] <= '0;
            end
            r_idx       <= '0;
            r_sum       <= '0;
            r_sum_data  <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (w_cap) begin
                for (int unsigned i = 0; i < VEC_SIZE; i++) begin
                    r_buf[i] <= bus.in_vec[i];
                end
                r_idx <= '0;
                r_sum <= '0;
            end else if (w_fire) begin
                if (w_last) begin
                    r_sum_data  <= r_sum + w_elem;
                    r_sum_valid <= 1'b1;
                end else begin
                    r_sum <= r_sum + w_elem;
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule
